// File: rtl/fifo_tx_pkg.sv
// fifo_tx_pkg: shared sizes and types for the FIFO-to-AXIS egress path.
package fifo_tx_pkg;
   localparam int BUF_DEPTH = 3;
   typedef logic [1:0] buf_idx_t;
   typedef logic [1:0] buf_cnt_t;
   function automatic buf_idx_t next_idx(input buf_idx_t i);
      return (i == buf_idx_t'(BUF_DEPTH - 1)) ? '0 : i + 2'd1;
   endfunction
endpackage

// File: rtl/fifo_tx_prefetch_buf.sv
// fifo_tx_prefetch_buf: 3-entry circular prefetch buffer with push/pop, occupancy and head word.
module fifo_tx_prefetch_buf
   import fifo_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   output buf_cnt_t              count,
   output logic [DATA_WIDTH-1:0] head
);
   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   buf_idx_t wr_ptr, rd_ptr;
   assign head = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (rst) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= next_idx(wr_ptr);
         end
         if (pop) rd_ptr <= next_idx(rd_ptr);
         count <= count + buf_cnt_t'(push) - buf_cnt_t'(pop);
      end
   end
endmodule

// File: rtl/fifo_to_axis_tx.sv
// fifo_to_axis_tx: drains a 1-cycle-latency FIFO read port into an AXI4-Stream master with TLAST framing.
// Define FIFO_TX_STATS_EN to add the stat_beats/stat_pkts handshake counters.
module fifo_to_axis_tx
   import fifo_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [LEN_WIDTH-1:0]  pkt_len,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   input  logic                  fifo_empty,
   output logic                  fifo_rena,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
`ifdef FIFO_TX_STATS_EN
   ,
   output logic [31:0]           stat_beats,
   output logic [31:0]           stat_pkts
`endif
);
   buf_cnt_t count;
   logic inflight, pop, first_hold;
   logic [LEN_WIDTH-1:0] beat_cnt, len_q, eff_len;
   assign fifo_rena     = ~rst & enable & ~fifo_empty & (({1'b0, count} + {2'b0, inflight}) < 3'd3);
   assign m_axis_tvalid = count != '0;
   assign pop           = m_axis_tvalid & m_axis_tready;
   // pkt_len follows the input only until a first beat has been shown, so a stalled first beat keeps its tlast
   always_comb eff_len = (beat_cnt == '0 && !first_hold) ? ((pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len) : len_q;
   assign m_axis_tlast  = m_axis_tvalid & (beat_cnt == eff_len - LEN_WIDTH'(1));
   fifo_tx_prefetch_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .din   (fifo_rdata),
      .pop   (pop),
      .count (count),
      .head  (m_axis_tdata)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight   <= 1'b0;
         beat_cnt   <= '0;
         len_q      <= LEN_WIDTH'(1);
         first_hold <= 1'b0;
      end else begin
         inflight   <= fifo_rena;
         first_hold <= m_axis_tvalid & ~m_axis_tready & (beat_cnt == '0);
         if (beat_cnt == '0) len_q <= eff_len;
         if (pop) beat_cnt <= m_axis_tlast ? '0 : beat_cnt + LEN_WIDTH'(1);
      end
   end
`ifdef FIFO_TX_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_beats <= '0;
         stat_pkts  <= '0;
      end else begin
         stat_beats <= stat_beats + 32'(pop);
         stat_pkts  <= stat_pkts + 32'(pop & m_axis_tlast);
      end
   end
`endif
endmodule

// File: tb/tb_fifo_to_axis_tx.sv
// tb_fifo_to_axis_tx: random and directed stimulus against a queue-based FIFO and packet model.
// Define FIFO_TX_STATS_EN to also check the stats counters.
module tb_fifo_to_axis_tx;
   localparam int DW = 32;
   localparam int LW = 16;
   logic clk = 1'b0, rst = 1'b1, enable = 1'b0, fifo_empty = 1'b1, m_axis_tready = 1'b0;
   logic fifo_rena, m_axis_tvalid, m_axis_tlast;
   logic [LW-1:0] pkt_len = 16'd4;
   logic [DW-1:0] fifo_rdata = '0, m_axis_tdata;
`ifdef FIFO_TX_STATS_EN
   logic [31:0] stat_beats, stat_pkts;
`endif
   always #5 clk = ~clk;
   fifo_to_axis_tx #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .pkt_len       (pkt_len),
      .fifo_rdata    (fifo_rdata),
      .fifo_empty    (fifo_empty),
      .fifo_rena     (fifo_rena),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast)
`ifdef FIFO_TX_STATS_EN
      ,
      .stat_beats    (stat_beats),
      .stat_pkts     (stat_pkts)
`endif
   );
   int checks = 0, errors = 0, cyc = 0;
   int beat_idx = 0, cur_len = 1, hs_total = 0, first_rena = -1, first_valid = -1;
   logic [DW-1:0] fifo_q[$], exp_q[$];
   logic [DW-1:0] prev_data = '0, word_ctr = 32'h100;
   logic [31:0] n_beats = '0, n_pkts = '0;
   logic rena_s = 1'b0, prev_stall = 1'b0, prev_last = 1'b0, last_hs_last = 1'b0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   task automatic push_word(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      fifo_empty = 1'b0;
   endtask
   // Observe the stream at the negedge, then let the FIFO model answer a read strobe just after the posedge.
   task automatic tick();
      logic exp_last;
      @(negedge clk);
      rena_s = fifo_rena;
      if (rst) begin
         exp_q.delete();
         beat_idx   = 0;
         n_beats    = '0;
         n_pkts     = '0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", m_axis_tvalid, 1);
            check("hold_data", m_axis_tdata, prev_data);
            check("hold_last", m_axis_tlast, prev_last);
         end
         if (fifo_rena) begin
            check("rena_empty", fifo_empty, 0);
            check("rena_enable", enable, 1);
            check("rena_room", exp_q.size() < 3, 1);
            if (first_rena < 0) first_rena = cyc;
         end
         if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
`ifdef FIFO_TX_STATS_EN
         check("stat_beats", stat_beats, n_beats);
         check("stat_pkts", stat_pkts, n_pkts);
`endif
         if (m_axis_tvalid && m_axis_tready) begin
            if (beat_idx == 0) cur_len = (pkt_len == '0) ? 1 : int'(pkt_len);
            exp_last = (beat_idx == cur_len - 1);
            if (exp_q.size() == 0) check("spurious_beat", 1, 0);
            else check("tdata", m_axis_tdata, exp_q.pop_front());
            check("tlast", m_axis_tlast, exp_last);
            beat_idx     = exp_last ? 0 : beat_idx + 1;
            n_beats      = n_beats + 1;
            n_pkts       = n_pkts + 32'(exp_last);
            hs_total     = hs_total + 1;
            last_hs_last = m_axis_tlast;
         end
         prev_stall = m_axis_tvalid & ~m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
      end
      @(posedge clk);
      #1;
      if (rena_s && fifo_q.size() != 0) begin
         fifo_rdata = fifo_q.pop_front();
         exp_q.push_back(fifo_rdata);
      end
      fifo_empty = (fifo_q.size() == 0);
      cyc++;
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic wait_idle(input string tag, input int max);
      int i;
      for (i = 0; i < max; i++) begin
         if (fifo_q.size() == 0 && exp_q.size() == 0 && !m_axis_tvalid) break;
         tick();
      end
      if (i == max) check(tag, 0, 1);
   endtask
   initial begin
      int hs0, w;
      logic [3:0] rpat;
      rpat = 4'b1001;
      // 1: preload under reset, then back-to-back drain
      enable = 1'b1;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 8; i++) push_word(32'h10 + 32'(i));
      ticks(3);
      check("rst_rena", fifo_rena, 0);
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_tdata", m_axis_tdata, 0);
      rst = 1'b0;
      hs0 = hs_total;
      for (int i = 0; i < 20 && first_valid < 0; i++) tick();
      check("first_latency", first_valid - first_rena, 2);
      ticks(7);
      check("b2b_beats", hs_total - hs0, 8);
      wait_idle("idle_t1", 40);
      // 2: backpressure 1,0,0,1
      for (int i = 0; i < 12; i++) push_word(32'h200 + 32'(i));
      hs0 = hs_total;
      for (int i = 0; i < 80 && hs_total - hs0 < 12; i++) begin
         m_axis_tready = rpat[i % 4];
         tick();
      end
      check("bp_beats", hs_total - hs0, 12);
      m_axis_tready = 1'b1;
      wait_idle("idle_t2", 40);
      // 3: pkt_len 0, 1, then a mid-packet change 3->5
      pkt_len = '0;
      for (int i = 0; i < 4; i++) push_word(32'h300 + 32'(i));
      wait_idle("idle_t3a", 40);
      pkt_len = 16'd1;
      for (int i = 0; i < 3; i++) push_word(32'h310 + 32'(i));
      wait_idle("idle_t3b", 40);
      pkt_len = 16'd3;
      for (int i = 0; i < 8; i++) push_word(32'h320 + 32'(i));
      for (int i = 0; i < 20 && beat_idx != 1; i++) tick();
      check("t3_at_beat1", beat_idx, 1);
      pkt_len = 16'd5;
      wait_idle("idle_t3c", 40);
      check("t3_end_last", last_hs_last, 1);
      // 4: FIFO runs dry mid-packet
      pkt_len = 16'd4;
      for (int i = 0; i < 3; i++) push_word(32'h400 + 32'(i));
      ticks(10);
      check("t4_tvalid_dry", m_axis_tvalid, 0);
      check("t4_tlast_dry", m_axis_tlast, 0);
      check("t4_last3", last_hs_last, 0);
      push_word(32'h403);
      wait_idle("idle_t4", 40);
      check("t4_last4", last_hs_last, 1);
      // 5: enable drops with a read inflight
      enable = 1'b0;
      m_axis_tready = 1'b0;
      for (int i = 0; i < 6; i++) push_word(32'h500 + 32'(i));
      ticks(2);
      enable = 1'b1;
      ticks(2);
      enable = 1'b0;
      hs0 = hs_total;
      m_axis_tready = 1'b1;
      ticks(10);
      check("t5_drained", hs_total - hs0, 2);
      check("t5_fifo_left", fifo_q.size(), 4);
      check("t5_tvalid", m_axis_tvalid, 0);
      enable = 1'b1;
      wait_idle("idle_t5", 40);
      // 6: reset mid-packet with two beats buffered
      m_axis_tready = 1'b0;
      push_word(32'h600);
      push_word(32'h601);
      ticks(5);
      check("t6_pre_valid", m_axis_tvalid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_tvalid", m_axis_tvalid, 0);
      check("t6_beat_cnt", dut.beat_cnt, 0);
`ifdef FIFO_TX_STATS_EN
      check("t6_stat_beats", stat_beats, 0);
      check("t6_stat_pkts", stat_pkts, 0);
`endif
      pkt_len = 16'd3;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 3; i++) push_word(32'h610 + 32'(i));
      wait_idle("idle_t6", 40);
      check("t6_new_pkt_last", last_hs_last, 1);
      // random traffic
      for (int b = 0; b < 25; b++) begin
         if (fifo_q.size() == 0 && exp_q.size() == 0 && !m_axis_tvalid) pkt_len = LW'($urandom_range(0, 6));
         w = int'($urandom_range(1, 20));
         for (int i = 0; i < w; i++) begin
            push_word(word_ctr ^ ($urandom & 32'hffff_0000));
            word_ctr = word_ctr + 1;
         end
         for (int i = 0; i < int'($urandom_range(5, 30)); i++) begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 7) != 0);
            tick();
         end
      end
      enable = 1'b1;
      m_axis_tready = 1'b1;
      wait_idle("idle_rand", 400);
      check("rand_fifo_empty", fifo_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
